pool_divide: RTL
================

POOL_DIVIDE -- requirements
Module: pool_divide

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, meaning the width of the averaged output sample.
REQ-002 SHALL have parameter POOL_SIZE, default 10, meaning the divisor (number of samples summed upstream); legal range is 1 or more.
REQ-003 SHALL have parameter ROUND, default 0, meaning 0 = truncate quotient, 1 = round half-up.
REQ-004 SHALL derive localparam ACC_WIDTH = DATA_WIDTH + clog2(POOL_SIZE), using clog2 from cnn1d_pkg.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port div_ready_in, output, 1 bit: the block can accept an input sum.
REQ-008 SHALL have port div_valid_in, input, 1 bit: div_data_in is valid.
REQ-009 SHALL have port div_data_in, input, ACC_WIDTH bits: unsigned pooled sum from the upstream accumulator.
REQ-010 SHALL have port div_ready_out, input, 1 bit: the downstream stage can accept data.
REQ-011 SHALL have port div_valid_out, output, 1 bit: div_data_out is valid.
REQ-012 SHALL have port div_data_out, output, DATA_WIDTH bits: unsigned average, floor or rounded sum/POOL_SIZE.

Function
REQ-013 SHALL implement an FSM with states IDLE, DIVIDE and DONE.
REQ-014 SHALL, in IDLE, hold div_ready_in=1 and div_valid_out=0.
REQ-015 SHALL, on an input handshake (div_valid_in && div_ready_in) in IDLE, capture the dividend (div_data_in, plus POOL_SIZE/2 if ROUND=1, held in ACC_WIDTH+1 bits with no overflow) and enter DIVIDE; div_ready_in is 0 from the next cycle.
REQ-016 SHALL, in DIVIDE, perform restoring division by the constant POOL_SIZE, one quotient bit per cycle, MSB first, for exactly ACC_WIDTH+1 cycles; a bit counter counts the iterations.
REQ-017 SHALL, on the final iteration, enter DONE with div_valid_out=1 registered; latency is ACC_WIDTH+1 clocks from the input-handshake edge to div_valid_out high (17 at defaults).
REQ-018 SHALL saturate div_data_out to 2^DATA_WIDTH-1 when the quotient exceeds DATA_WIDTH bits; otherwise div_data_out is the quotient's low DATA_WIDTH bits.
REQ-019 SHALL, in DONE, hold div_data_out and div_valid_out stable while div_ready_out=0, with no timeout.
REQ-020 SHALL, on an output handshake in DONE, clear div_valid_out and return to IDLE; div_ready_in rises on the following cycle, so there is no same-cycle pass-through.
REQ-021 SHALL ignore div_valid_in and div_data_in outside IDLE.
REQ-022 SHALL retain div_data_out after the output handshake until the next result is loaded.
REQ-023 SHALL have a maximum throughput of one result per ACC_WIDTH+3 cycles when div_ready_out is held at 1.
REQ-024 SHALL, for POOL_SIZE=1, behave identically, with the output equal to the input and the same latency formula.

Reset
REQ-025 SHALL, while rst=0, asynchronously force: state IDLE, div_ready_in=1, div_valid_out=0, div_data_out=0, counter=0, working registers=0.
REQ-026 SHALL, when rst asserts mid-DIVIDE or in DONE, discard the partial or pending result; after release, no div_valid_out pulse appears without a new input handshake.
REQ-027 SHALL deassert reset internally without a glitch on outputs; the first handshake is accepted on the first rising edge after rst=1.

Verification
REQ-028 SHALL cover, at defaults with ROUND=0: input 40950 -> div_data_out=4095, div_valid_out high exactly 17 clocks after the handshake.
REQ-029 SHALL cover: input 47 with ROUND=0 -> 4; with ROUND=1 -> 5; input 45 with ROUND=1 -> 5; input 44 with ROUND=1 -> 4.
REQ-030 SHALL cover: input 65535 (max ACC_WIDTH=16) -> saturated 4095; input 0 -> 0.
REQ-031 SHALL cover: result 123 (input 1230) with div_ready_out held 0 for 20 cycles -> valid and data stable for all 20 cycles, div_ready_in=0 throughout; one handshake, then IDLE.
REQ-032 SHALL cover: rst pulsed low at DIVIDE iteration 8 -> outputs at reset values immediately (asynchronously); no output produced afterwards; a following input of 100 -> 10.
REQ-033 SHALL cover: a back-to-back stream of 100 random sums with random div_ready_out and div_valid_in -> every output matches a floor/round model, in order, with no drops or duplicates, and the spacing is at least 19 cycles.

Source files
------------

// File: rtl/pool_divide.sv
// Shared helpers for the 1-D CNN datapath, plus the pooling divider that turns an
// upstream window sum into an average by serial restoring division by a constant.
package cnn1d_pkg;
    // Ceiling log2; clog2(1) is 0 so a divide-by-one pool needs no extra bits.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction
endpackage

module pool_divide
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int POOL_SIZE  = 10,
    parameter int ROUND      = 0,
    localparam int ACC_WIDTH = DATA_WIDTH + clog2(POOL_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  div_ready_in,
    input  logic                  div_valid_in,
    input  logic [ACC_WIDTH-1:0]  div_data_in,
    input  logic                  div_ready_out,
    output logic                  div_valid_out,
    output logic [DATA_WIDTH-1:0] div_data_out
);
    // Handshake: a word moves on any rising edge where valid and ready are both 1;
    // valid never depends combinationally on ready, and both outputs are registered.

    localparam int DIV_W = ACC_WIDTH + 1;
    localparam int REM_W = clog2(POOL_SIZE) + 1;
    localparam int SH_W  = REM_W + 1;
    localparam int CNT_W = clog2(DIV_W + 1);

    localparam logic [DIV_W-1:0] ROUND_ADD = DIV_W'((ROUND != 0) ? (POOL_SIZE / 2) : 0);
    localparam logic [SH_W-1:0]  DIVISOR   = SH_W'(POOL_SIZE);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ACC_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic                  ready_in_q,  ready_in_d;
    logic                  valid_out_q, valid_out_d;
    logic [DATA_WIDTH-1:0] data_out_q,  data_out_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [DIV_W-1:0]      dvd_q,       dvd_d;
    logic [REM_W-1:0]      rem_q,       rem_d;
    logic [DIV_W-2:0]      quo_q,       quo_d;

    logic [SH_W-1:0]       rem_shift;
    logic                  q_bit;
    logic [DIV_W-1:0]      quo_next;
    logic                  quo_over;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem_q, dvd_q[DIV_W-1]};
        q_bit     = (rem_shift >= DIVISOR);
        quo_next  = {quo_q, q_bit};
        quo_over  = |quo_next[DIV_W-1:DATA_WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        ready_in_d  = ready_in_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        quo_d       = quo_q;

        case (state_q)
            IDLE: begin
                if (div_valid_in && ready_in_q) begin
                    dvd_d      = {1'b0, div_data_in} + ROUND_ADD;
                    rem_d      = '0;
                    quo_d      = '0;
                    cnt_d      = '0;
                    ready_in_d = 1'b0;
                    state_d    = DIVIDE;
                end
            end
            DIVIDE: begin
                dvd_d = {dvd_q[DIV_W-2:0], 1'b0};
                rem_d = q_bit ? REM_W'(rem_shift - DIVISOR) : REM_W'(rem_shift);
                quo_d = quo_next[DIV_W-2:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    cnt_d       = '0;
                    valid_out_d = 1'b1;
                    data_out_d  = quo_over ? '1 : quo_next[DATA_WIDTH-1:0];
                    state_d     = DONE;
                end
            end
            DONE: begin
                // Result is held indefinitely until the consumer takes it.
                if (div_ready_out) begin
                    valid_out_d = 1'b0;
                    ready_in_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                ready_in_d  = 1'b1;
                valid_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ready_in_q  <= 1'b1;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            cnt_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_in_q  <= ready_in_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
        end
    end

    assign div_ready_in  = ready_in_q;
    assign div_valid_out = valid_out_q;
    assign div_data_out  = data_out_q;

endmodule
